// File: rtl/v33_bus_responder.sv
// v33_bus_responder
// Target-side responder for the V33 bus control unit. Samples the CPU bus-cycle
// pins on the shared ce_1/ce_2 timebase, decodes each cycle, and turns memory
// and I/O cycles into one request/acknowledge transaction on a word-wide
// backing-store port. Interrupt-acknowledge and halt-acknowledge cycles are
// answered locally. Read data goes back on din and completion on n_ready, with
// WAIT_STATES extra T_2 periods inserted after the backing store acknowledges.
//
// Ports:
//   clk, n_reset           system clock, asynchronous active-low reset
//   ce_1, ce_2             phase-1 / phase-2 clock enables shared with the CPU
//   n_bcyst, n_dstb        bus cycle start / data strobe (active low)
//   r_w, m_io, busst1/0    cycle-type status
//   n_ube, addr, dout      upper byte enable, physical address, CPU write data
//   din, n_ready, bs16     read data, cycle complete (active low), bus size
//   tgt_*                  backing-store request port (req held until ack)
//   int_vector, int_ack    interrupt vector in, pulse after second INT_ACK
//   halted, bus_error      halt-acknowledge status, sticky protocol error
module v33_bus_responder #(
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        ce_1,
    input  logic        ce_2,
    input  logic        n_bcyst,
    input  logic        n_dstb,
    input  logic        r_w,
    input  logic        m_io,
    input  logic        busst0,
    input  logic        busst1,
    input  logic        n_ube,
    input  logic [23:0] addr,
    input  logic [15:0] dout,
    output logic [15:0] din,
    output logic        n_ready,
    output logic        bs16,
    output logic        tgt_req,
    output logic        tgt_mem,
    output logic        tgt_we,
    output logic [22:0] tgt_addr,
    output logic [1:0]  tgt_be,
    output logic [15:0] tgt_wdata,
    input  logic [15:0] tgt_rdata,
    input  logic        tgt_ack,
    input  logic [7:0]  int_vector,
    output logic        int_ack,
    output logic        halted,
    output logic        bus_error
);

    typedef enum logic [2:0] {
        R_IDLE,
        R_ADDR,
        R_ACCESS,
        R_WAIT,
        R_READY
    } state_t;

    typedef enum logic [1:0] {
        K_ACCESS,
        K_INTA,
        K_HALT,
        K_BAD
    } kind_t;

    // Wait-state counter is 4 bits wide; WAIT_STATES is expected in 0..15.
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    state_t     state;
    kind_t      kind;
    kind_t      dec_kind;
    logic       dec_write;
    logic [3:0] wait_cnt;
    logic       int_second;
    logic [1:0] busst;

    assign busst = {busst1, busst0};
    assign bs16  = 1'b1;

    // Cycle-type decode of the status pins as presented at cycle start.
    // Instruction fetch is a memory read regardless of r_w; anything not
    // listed is a protocol violation completed as a zero-data read.
    always_comb begin
        dec_kind  = K_BAD;
        dec_write = 1'b0;
        if (!m_io && r_w && busst == 2'b00) begin
            dec_kind = K_INTA;
        end else if (!m_io && busst == 2'b01) begin
            dec_kind  = K_ACCESS;
            dec_write = ~r_w;
        end else if (!m_io && !r_w && busst == 2'b11) begin
            dec_kind = K_HALT;
        end else if (m_io && busst == 2'b00) begin
            dec_kind = K_ACCESS;
        end else if (m_io && busst == 2'b01) begin
            dec_kind  = K_ACCESS;
            dec_write = ~r_w;
        end
    end

    // Bus cycle sequencer. All outputs are registered here.
    // Entering completion with WAIT_STATES=0 drives n_ready low immediately
    // so that the CPU sees ready on its first T_2 ce_1 (zero-wait cycle).
    // Otherwise R_WAIT lets WAIT_STATES ce_1 edges pass with n_ready high,
    // dropping n_ready on the last of them.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state      <= R_IDLE;
            kind       <= K_ACCESS;
            wait_cnt   <= 4'd0;
            int_second <= 1'b0;
            din        <= 16'hffff;
            n_ready    <= 1'b1;
            tgt_req    <= 1'b0;
            tgt_mem    <= 1'b0;
            tgt_we     <= 1'b0;
            tgt_addr   <= 23'd0;
            tgt_be     <= 2'b00;
            tgt_wdata  <= 16'd0;
            int_ack    <= 1'b0;
            halted     <= 1'b0;
            bus_error  <= 1'b0;
        end else begin
            int_ack <= 1'b0;

            // A cycle start while busy is flagged but otherwise ignored.
            if (ce_1 && !n_bcyst && state != R_IDLE) begin
                bus_error <= 1'b1;
            end

            case (state)
                R_IDLE: begin
                    if (ce_1 && !n_bcyst) begin
                        kind     <= dec_kind;
                        tgt_addr <= addr[23:1];
                        tgt_be   <= {~n_ube, ~addr[0]};
                        tgt_mem  <= m_io;
                        tgt_we   <= dec_write;
                        halted   <= 1'b0;
                        if (dec_kind == K_BAD) begin
                            bus_error <= 1'b1;
                        end
                        state <= R_ADDR;
                    end
                end

                R_ADDR: begin
                    if (ce_2 && !n_dstb) begin
                        tgt_wdata <= dout;
                        if (kind == K_ACCESS) begin
                            tgt_req <= 1'b1;
                            state   <= R_ACCESS;
                        end else begin
                            // Locally answered cycles: vector, or zero data.
                            if (kind == K_INTA) begin
                                din <= {8'h00, int_vector};
                            end else begin
                                din <= 16'h0000;
                            end
                            if (WAIT_STATES == 0) begin
                                n_ready <= 1'b0;
                                state   <= R_READY;
                            end else begin
                                wait_cnt <= WAIT_INIT;
                                state    <= R_WAIT;
                            end
                        end
                    end
                end

                R_ACCESS: begin
                    if (tgt_ack) begin
                        tgt_req <= 1'b0;
                        if (!tgt_we) begin
                            din <= tgt_rdata;
                        end
                        if (WAIT_STATES == 0) begin
                            n_ready <= 1'b0;
                            state   <= R_READY;
                        end else begin
                            wait_cnt <= WAIT_INIT;
                            state    <= R_WAIT;
                        end
                    end
                end

                R_WAIT: begin
                    if (ce_1) begin
                        if (wait_cnt <= 4'd1) begin
                            wait_cnt <= 4'd0;
                            n_ready  <= 1'b0;
                            state    <= R_READY;
                        end else begin
                            wait_cnt <= wait_cnt - 4'd1;
                        end
                    end
                end

                R_READY: begin
                    // The CPU samples the low n_ready on this same edge.
                    if (ce_1) begin
                        n_ready <= 1'b1;
                        state   <= R_IDLE;
                        if (kind == K_INTA) begin
                            if (int_second) begin
                                int_ack    <= 1'b1;
                                int_second <= 1'b0;
                            end else begin
                                int_second <= 1'b1;
                            end
                        end
                        if (kind == K_HALT) begin
                            halted <= 1'b1;
                        end
                    end
                end

                default: begin
                    state <= R_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_v33_bus_responder.sv
// tb_v33_bus_responder
// Drives CPU-side bus cycles into two responder instances (WAIT_STATES=0 and
// WAIT_STATES=3, selected by 'sel') and acts as the backing store. A 4-clk
// CPU state: ce_1 on phase 0, ce_2 on phase 2.
module tb_v33_bus_responder;

    logic        clk;
    logic [1:0]  phase;
    logic        n_reset;
    logic        ce_1;
    logic        ce_2;
    logic        n_bcyst;
    logic        n_dstb;
    logic        r_w;
    logic        m_io;
    logic        busst0;
    logic        busst1;
    logic        n_ube;
    logic [23:0] addr;
    logic [15:0] dout;
    logic [15:0] tgt_rdata;
    logic        tgt_ack;
    logic [7:0]  int_vector;
    logic        sel;

    logic        n_bcyst_0, n_bcyst_3, tgt_ack_0, tgt_ack_3;

    logic [15:0] din_0, din_3, din_s;
    logic        n_ready_0, n_ready_3, n_ready_s;
    logic        bs16_0, bs16_3, bs16_s;
    logic        tgt_req_0, tgt_req_3, tgt_req_s;
    logic        tgt_mem_0, tgt_mem_3, tgt_mem_s;
    logic        tgt_we_0, tgt_we_3, tgt_we_s;
    logic [22:0] tgt_addr_0, tgt_addr_3, tgt_addr_s;
    logic [1:0]  tgt_be_0, tgt_be_3, tgt_be_s;
    logic [15:0] tgt_wdata_0, tgt_wdata_3, tgt_wdata_s;
    logic        int_ack_0, int_ack_3, int_ack_s;
    logic        halted_0, halted_3, halted_s;
    logic        bus_error_0, bus_error_3, bus_error_s;

    int pass_count    = 0;
    int check_count   = 0;
    int int_ack_count = 0;

    typedef struct {
        logic        m_io;
        logic        r_w;
        logic [1:0]  busst;
        logic        n_ube;
        logic [23:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          ack_delay;
        logic        exp_req;
        logic        exp_mem;
        logic        exp_we;
        logic [1:0]  exp_be;
        logic [22:0] exp_addr;
        logic [15:0] exp_wdata;
        logic [15:0] exp_din;
        int          exp_waits;
        logic        exp_err;
    } vec_t;

    vec_t vecs[6];

    assign ce_1 = (phase == 2'd0);
    assign ce_2 = (phase == 2'd2);

    assign n_bcyst_0 = sel ? 1'b1 : n_bcyst;
    assign n_bcyst_3 = sel ? n_bcyst : 1'b1;
    assign tgt_ack_0 = sel ? 1'b0 : tgt_ack;
    assign tgt_ack_3 = sel ? tgt_ack : 1'b0;

    assign din_s       = sel ? din_3       : din_0;
    assign n_ready_s   = sel ? n_ready_3   : n_ready_0;
    assign bs16_s      = sel ? bs16_3      : bs16_0;
    assign tgt_req_s   = sel ? tgt_req_3   : tgt_req_0;
    assign tgt_mem_s   = sel ? tgt_mem_3   : tgt_mem_0;
    assign tgt_we_s    = sel ? tgt_we_3    : tgt_we_0;
    assign tgt_addr_s  = sel ? tgt_addr_3  : tgt_addr_0;
    assign tgt_be_s    = sel ? tgt_be_3    : tgt_be_0;
    assign tgt_wdata_s = sel ? tgt_wdata_3 : tgt_wdata_0;
    assign int_ack_s   = sel ? int_ack_3   : int_ack_0;
    assign halted_s    = sel ? halted_3    : halted_0;
    assign bus_error_s = sel ? bus_error_3 : bus_error_0;

    v33_bus_responder #(.WAIT_STATES(0)) dut0 (
        .clk(clk), .n_reset(n_reset), .ce_1(ce_1), .ce_2(ce_2),
        .n_bcyst(n_bcyst_0), .n_dstb(n_dstb), .r_w(r_w), .m_io(m_io),
        .busst0(busst0), .busst1(busst1), .n_ube(n_ube), .addr(addr),
        .dout(dout), .din(din_0), .n_ready(n_ready_0), .bs16(bs16_0),
        .tgt_req(tgt_req_0), .tgt_mem(tgt_mem_0), .tgt_we(tgt_we_0),
        .tgt_addr(tgt_addr_0), .tgt_be(tgt_be_0), .tgt_wdata(tgt_wdata_0),
        .tgt_rdata(tgt_rdata), .tgt_ack(tgt_ack_0), .int_vector(int_vector),
        .int_ack(int_ack_0), .halted(halted_0), .bus_error(bus_error_0)
    );

    v33_bus_responder #(.WAIT_STATES(3)) dut3 (
        .clk(clk), .n_reset(n_reset), .ce_1(ce_1), .ce_2(ce_2),
        .n_bcyst(n_bcyst_3), .n_dstb(n_dstb), .r_w(r_w), .m_io(m_io),
        .busst0(busst0), .busst1(busst1), .n_ube(n_ube), .addr(addr),
        .dout(dout), .din(din_3), .n_ready(n_ready_3), .bs16(bs16_3),
        .tgt_req(tgt_req_3), .tgt_mem(tgt_mem_3), .tgt_we(tgt_we_3),
        .tgt_addr(tgt_addr_3), .tgt_be(tgt_be_3), .tgt_wdata(tgt_wdata_3),
        .tgt_rdata(tgt_rdata), .tgt_ack(tgt_ack_3), .int_vector(int_vector),
        .int_ack(int_ack_3), .halted(halted_3), .bus_error(bus_error_3)
    );

    // Clock and CPU state phase; phase advances on the falling edge so it
    // is stable around every rising edge.
    initial begin
        clk   = 1'b0;
        phase = 2'd0;
        forever begin
            #5 clk = 1'b1;
            #5 clk = 1'b0;
            phase = phase + 2'd1;
        end
    end

    // Advance one clk and land 2 time units after the rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
        if (int_ack_s) int_ack_count++;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // One complete CPU bus cycle. Counts T_2 ce_1 samples with n_ready high
    // before the ready sample, acknowledges tgt_req after ack_delay clks, and
    // optionally pulses a stray n_bcyst while the access is outstanding.
    task automatic applyStimulus(input logic c_mio, input logic c_rw,
                                 input logic [1:0] c_busst, input logic c_ube,
                                 input logic [23:0] c_addr,
                                 input logic [15:0] c_wdata,
                                 input logic [15:0] c_rdata,
                                 input int ack_delay, input bit stray,
                                 output int waits, output int req_clks,
                                 output bit done);
        int req_cnt;
        bit acked;
        waits    = 0;
        req_clks = 0;
        done     = 1'b0;
        req_cnt  = 0;
        acked    = 1'b0;
        while (phase != 2'd3) tick();
        m_io      = c_mio;
        r_w       = c_rw;
        busst1    = c_busst[1];
        busst0    = c_busst[0];
        n_ube     = c_ube;
        addr      = c_addr;
        dout      = c_wdata;
        tgt_rdata = c_rdata;
        n_bcyst   = 1'b0;
        tick();
        n_bcyst = 1'b1;
        n_dstb  = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            tick();
            tgt_ack = 1'b0;
            n_bcyst = 1'b1;
            if (tgt_req_s) begin
                req_clks++;
                if (!acked) begin
                    if (req_cnt == ack_delay) begin
                        tgt_ack = 1'b1;
                        acked   = 1'b1;
                    end else begin
                        req_cnt++;
                    end
                end
                if (stray && !acked && phase == 2'd3) n_bcyst = 1'b0;
            end
            if (phase == 2'd3) begin
                if (n_ready_s == 1'b0) done = 1'b1;
                else waits++;
            end
        end
        if (done) tick();
        n_dstb  = 1'b1;
        tgt_ack = 1'b0;
        n_bcyst = 1'b1;
    endtask

    initial begin
        int waits;
        int req_clks;
        bit done;
        int ack_before;

        n_reset    = 1'b0;
        n_bcyst    = 1'b1;
        n_dstb     = 1'b1;
        r_w        = 1'b1;
        m_io       = 1'b0;
        busst0     = 1'b0;
        busst1     = 1'b0;
        n_ube      = 1'b1;
        addr       = 24'd0;
        dout       = 16'd0;
        tgt_rdata  = 16'd0;
        tgt_ack    = 1'b0;
        int_vector = 8'h21;
        sel        = 1'b0;

        vecs[0] = '{1'b1, 1'b1, 2'b01, 1'b0, 24'h001000, 16'h0000, 16'hBEEF, 0,
                    1'b1, 1'b1, 1'b0, 2'b11, 23'h000800, 16'h0000, 16'hBEEF, 0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 2'b01, 1'b0, 24'h000101, 16'h5A00, 16'h0000, 0,
                    1'b1, 1'b1, 1'b1, 2'b10, 23'h000080, 16'h5A00, 16'hBEEF, 0, 1'b0};
        vecs[2] = '{1'b1, 1'b1, 2'b00, 1'b0, 24'h000202, 16'h0000, 16'h1234, 0,
                    1'b1, 1'b1, 1'b0, 2'b11, 23'h000101, 16'h0000, 16'h1234, 0, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 2'b01, 1'b1, 24'h000400, 16'h0000, 16'h00AA, 6,
                    1'b1, 1'b1, 1'b0, 2'b01, 23'h000200, 16'h0000, 16'h00AA, 2, 1'b0};
        vecs[4] = '{1'b0, 1'b0, 2'b01, 1'b1, 24'h000040, 16'h00C3, 16'h0000, 0,
                    1'b1, 1'b0, 1'b1, 2'b01, 23'h000020, 16'h00C3, 16'h00AA, 0, 1'b0};
        vecs[5] = '{1'b1, 1'b1, 2'b10, 1'b0, 24'h000800, 16'h0000, 16'h9999, 0,
                    1'b0, 1'b0, 1'b0, 2'b00, 23'h000000, 16'h0000, 16'h0000, 0, 1'b1};

        tick();
        tick();
        tick();
        n_reset = 1'b1;
        tick();

        checkOutput("rst_din",       32'(din_s),       32'h0000ffff);
        checkOutput("rst_n_ready",   32'(n_ready_s),   32'd1);
        checkOutput("rst_bs16",      32'(bs16_s),      32'd1);
        checkOutput("rst_tgt_req",   32'(tgt_req_s),   32'd0);
        checkOutput("rst_tgt_mem",   32'(tgt_mem_s),   32'd0);
        checkOutput("rst_tgt_we",    32'(tgt_we_s),    32'd0);
        checkOutput("rst_tgt_addr",  32'(tgt_addr_s),  32'd0);
        checkOutput("rst_tgt_be",    32'(tgt_be_s),    32'd0);
        checkOutput("rst_tgt_wdata", 32'(tgt_wdata_s), 32'd0);
        checkOutput("rst_int_ack",   32'(int_ack_s),   32'd0);
        checkOutput("rst_halted",    32'(halted_s),    32'd0);
        checkOutput("rst_bus_error", 32'(bus_error_s), 32'd0);

        // Table of single bus cycles against the zero-wait instance.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].m_io, vecs[i].r_w, vecs[i].busst, vecs[i].n_ube,
                          vecs[i].addr, vecs[i].wdata, vecs[i].rdata,
                          vecs[i].ack_delay, 1'b0, waits, req_clks, done);
            checkOutput($sformatf("v%0d_done", i), 32'(done), 32'd1);
            checkOutput($sformatf("v%0d_req", i), 32'(req_clks > 0), 32'(vecs[i].exp_req));
            if (vecs[i].exp_req) begin
                checkOutput($sformatf("v%0d_mem", i),   32'(tgt_mem_s),   32'(vecs[i].exp_mem));
                checkOutput($sformatf("v%0d_we", i),    32'(tgt_we_s),    32'(vecs[i].exp_we));
                checkOutput($sformatf("v%0d_be", i),    32'(tgt_be_s),    32'(vecs[i].exp_be));
                checkOutput($sformatf("v%0d_addr", i),  32'(tgt_addr_s),  32'(vecs[i].exp_addr));
                checkOutput($sformatf("v%0d_wdata", i), 32'(tgt_wdata_s), 32'(vecs[i].exp_wdata));
            end
            checkOutput($sformatf("v%0d_din", i),     32'(din_s),       32'(vecs[i].exp_din));
            checkOutput($sformatf("v%0d_waits", i),   32'(waits),       32'(vecs[i].exp_waits));
            checkOutput($sformatf("v%0d_err", i),     32'(bus_error_s), 32'(vecs[i].exp_err));
            checkOutput($sformatf("v%0d_release", i), 32'(n_ready_s),   32'd1);
        end

        // Two interrupt-acknowledge cycles: vector on both, one int_ack pulse.
        int_vector = 8'h21;
        ack_before = int_ack_count;
        applyStimulus(1'b0, 1'b1, 2'b00, 1'b1, 24'h000000, 16'h0000, 16'h0000,
                      0, 1'b0, waits, req_clks, done);
        checkOutput("inta1_done", 32'(done), 32'd1);
        checkOutput("inta1_din", 32'(din_s), 32'h00000021);
        checkOutput("inta1_req", 32'(req_clks), 32'd0);
        checkOutput("inta1_pulses", 32'(int_ack_count - ack_before), 32'd0);
        applyStimulus(1'b0, 1'b1, 2'b00, 1'b1, 24'h000000, 16'h0000, 16'h0000,
                      0, 1'b0, waits, req_clks, done);
        tick();
        tick();
        checkOutput("inta2_done", 32'(done), 32'd1);
        checkOutput("inta2_din", 32'(din_s), 32'h00000021);
        checkOutput("inta2_req", 32'(req_clks), 32'd0);
        checkOutput("inta2_pulses", 32'(int_ack_count - ack_before), 32'd1);

        // Halt acknowledge, then a fetch clears halted.
        applyStimulus(1'b0, 1'b0, 2'b11, 1'b1, 24'h000000, 16'h0000, 16'h0000,
                      0, 1'b0, waits, req_clks, done);
        checkOutput("halt_done", 32'(done), 32'd1);
        checkOutput("halt_req", 32'(req_clks), 32'd0);
        checkOutput("halt_halted", 32'(halted_s), 32'd1);
        applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 24'h000010, 16'h0000, 16'h0F0F,
                      0, 1'b0, waits, req_clks, done);
        checkOutput("fetch_done", 32'(done), 32'd1);
        checkOutput("fetch_halted", 32'(halted_s), 32'd0);
        checkOutput("fetch_din", 32'(din_s), 32'h00000f0f);

        // I/O read through the three-wait-state instance.
        sel = 1'b1;
        applyStimulus(1'b0, 1'b1, 2'b01, 1'b0, 24'h000040, 16'h0000, 16'h7777,
                      0, 1'b0, waits, req_clks, done);
        checkOutput("ws3_done", 32'(done), 32'd1);
        checkOutput("ws3_mem", 32'(tgt_mem_s), 32'd0);
        checkOutput("ws3_addr", 32'(tgt_addr_s), 32'h00000020);
        checkOutput("ws3_waits", 32'(waits), 32'd3);
        checkOutput("ws3_din", 32'(din_s), 32'h00007777);
        checkOutput("ws3_release", 32'(n_ready_s), 32'd1);
        sel = 1'b0;

        // Reset while the backing-store request is outstanding.
        while (phase != 2'd3) tick();
        m_io      = 1'b1;
        r_w       = 1'b1;
        busst1    = 1'b0;
        busst0    = 1'b1;
        n_ube     = 1'b0;
        addr      = 24'h002000;
        dout      = 16'h0000;
        tgt_rdata = 16'h5555;
        n_bcyst   = 1'b0;
        tick();
        n_bcyst = 1'b1;
        n_dstb  = 1'b0;
        for (int i = 0; i < 8 && !tgt_req_s; i++) tick();
        checkOutput("abort_req_up", 32'(tgt_req_s), 32'd1);
        n_reset = 1'b0;
        #1;
        checkOutput("abort_tgt_req",   32'(tgt_req_s),   32'd0);
        checkOutput("abort_n_ready",   32'(n_ready_s),   32'd1);
        checkOutput("abort_din",       32'(din_s),       32'h0000ffff);
        checkOutput("abort_tgt_addr",  32'(tgt_addr_s),  32'd0);
        checkOutput("abort_tgt_be",    32'(tgt_be_s),    32'd0);
        checkOutput("abort_tgt_mem",   32'(tgt_mem_s),   32'd0);
        checkOutput("abort_bus_error", 32'(bus_error_s), 32'd0);
        tick();
        n_reset = 1'b1;
        n_dstb  = 1'b1;
        tgt_ack = 1'b1;
        tick();
        tgt_ack = 1'b0;
        tick();
        checkOutput("late_ack_req", 32'(tgt_req_s), 32'd0);
        checkOutput("late_ack_n_ready", 32'(n_ready_s), 32'd1);
        checkOutput("late_ack_din", 32'(din_s), 32'h0000ffff);

        // Stray cycle start during R_ACCESS: flagged, cycle still completes.
        applyStimulus(1'b1, 1'b1, 2'b01, 1'b0, 24'h003000, 16'h0000, 16'h4321,
                      6, 1'b1, waits, req_clks, done);
        checkOutput("stray_done", 32'(done), 32'd1);
        checkOutput("stray_bus_error", 32'(bus_error_s), 32'd1);
        checkOutput("stray_din", 32'(din_s), 32'h00004321);
        checkOutput("stray_waits", 32'(waits), 32'd2);
        checkOutput("stray_release", 32'(n_ready_s), 32'd1);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
